// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants and the fetch-stage state type.
package riscv_pkg;

    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
    localparam logic [31:0] INST_ECALL = 32'h0000_0073;
    localparam logic [31:0] INST_NOP   = 32'h0000_0013;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

endpackage : riscv_pkg

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: valid/ready holding register for inst, pc and pc+4,
// with load, hold and flush controls.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter logic [31:0] NOP_INST = INST_NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic        ready,
    input  logic [31:0] d_inst,
    input  logic [31:0] d_pc,
    input  logic [31:0] d_pc4,
    output logic        valid,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc4
);

    // Priority: flush > load > drop-after-handshake > hold.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            inst  <= NOP_INST;
            pc    <= '0;
            pc4   <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            inst  <= NOP_INST;
        end else if (load) begin
            valid <= 1'b1;
            inst  <= d_inst;
            pc    <= d_pc;
            pc4   <= d_pc4;
        end else if (valid && ready) begin
            // Word consumed with nothing behind it: present a NOP bubble.
            valid <= 1'b0;
            inst  <= NOP_INST;
        end
    end

endmodule : if_id_reg

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, combinational imem addressing, IF/ID register,
// redirect flush and halt-on-ECALL.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 6,
    parameter logic [31:0] NOP_INST = INST_NOP
) (
    input  logic               clk,
    input  logic               rst,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               id_ready,
    output logic               id_valid,
    output logic [31:0]        id_inst,
    output logic [31:0]        id_pc,
    output logic [31:0]        id_pc4,
    output logic               halted
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pc_plus4;
    logic         adv;
    logic         is_ecall;
    logic         running;

    assign pc_plus4  = pc_q + 32'd4;
    assign imem_addr = pc_q[IMEM_AW+1:2];
    assign is_ecall  = (imem_data == INST_ECALL);
    assign adv       = running && (!id_valid || id_ready) && !redirect_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect_valid) begin
            state_d = RUN;
            pc_d    = {redirect_pc[31:2], 2'b00};
        end else if (adv) begin
            // ECALL is captured but the PC stays on it; fetch stops here.
            if (is_ecall) state_d = HALT;
            else          pc_d    = pc_plus4;
        end
    end

    always_comb begin
        running = (state_q == RUN);
        halted  = (state_q == HALT);
    end

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id (
        .clk    (clk),
        .rst    (rst),
        .load   (adv),
        .flush  (redirect_valid),
        .ready  (id_ready),
        .d_inst (imem_data),
        .d_pc   (pc_q),
        .d_pc4  (pc_plus4),
        .valid  (id_valid),
        .inst   (id_inst),
        .pc     (id_pc),
        .pc4    (id_pc4)
    );

endmodule : fetch_stage

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RISCV_Processor pipeline, sitting directly upstream of the instruction memory and feeding the decode stage. Holds the program counter, drives the word address of the combinational-read instruction memory, and registers the returned word with its PC into an IF/ID register with a valid/ready handshake toward decode. Handles control-flow redirects from execute by flushing the fetched word, and halts fetch on ECALL.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `IMEM_AW`, 6: instruction memory word-address width (64 words).
- `NOP_INST`, 32'h0000_0013: word driven on `id_inst` while `id_valid`=0.
- `clk`  in  1  the single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `imem_addr`  out  IMEM_AW  word address to instruction memory, = `pc[IMEM_AW+1:2]`.
- `imem_data`  in  32  instruction word, valid combinationally in the same cycle.
- `redirect_valid`  in  1  taken branch/jump from execute.
- `redirect_pc`  in  32  target PC; bits [1:0] ignored (forced to 0).
- `id_ready`  in  1  decode accepts the IF/ID word this cycle.
- `id_valid`  out  1  IF/ID word valid.
- `id_inst`  out  32  fetched instruction.
- `id_pc`  out  32  PC of `id_inst`.
- `id_pc4`  out  32  `id_pc`+4 (link value for JAL/JALR).
- `halted`  out  1  ECALL fetched; fetch stopped.

## Operation
- State machine: RUN, HALT. Reset → RUN.
- Advance condition `adv` = RUN && (!id_valid || id_ready) && !redirect_valid.
- On `adv`: IF/ID ← {imem_data, pc, pc+4}, `id_valid`←1, `pc`←pc+4.
- ECALL: if `adv` and `imem_data`==32'h0000_0073: word is captured normally, `pc` is NOT incremented, state → HALT, `halted`←1.
- HALT: no fetch; `pc` frozen; captured ECALL remains presented until accepted (`id_valid`→0 after the `id_ready` handshake); leaves HALT only on redirect or reset.
- Redirect (any state, highest priority): `pc`←{redirect_pc[31:2],2'b00}, `id_valid`←0, `id_inst`←NOP_INST, state→RUN, `halted`←0.
- Stall (`id_valid` && !`id_ready`): `pc`, `id_inst`, `id_pc`, `id_pc4` held stable; no memory word is lost (refetched from unchanged `pc`).
- Arithmetic: PC adds are 32-bit modulo 2^32; `imem_addr` wraps modulo 2^IMEM_AW words, PC itself does not.
- Decode accepted-word count: each word delivered exactly once per handshake (`id_valid`&&`id_ready`).

## Timing
- Reset values: `pc`=RESET_PC, `id_valid`=0, `id_inst`=NOP_INST, `id_pc`=0, `id_pc4`=0, `halted`=0, `imem_addr`=RESET_PC[IMEM_AW+1:2].
- Memory read latency 0 (combinational); PC→`id_*` latency 1 cycle.
- First edge after reset release: `id_valid`=1, `id_pc`=RESET_PC.
- Redirect sampled at edge N: bubble in cycle N..N+1 (`id_valid`=0), target word valid after edge N+1.
- Redirect concurrent with stall: redirect wins; held word discarded.
- Redirect concurrent with ECALL fetch: redirect wins; ECALL not captured, no HALT.
- Reset asserted mid-stall or in HALT: all state returns to reset values immediately (asynchronous).
- Sustained throughput: one word per cycle with `id_ready`=1.

## Structure
- Shared package `riscv_pkg`: `OPC_SYSTEM` (7'b1110011), `INST_ECALL` (32'h0000_0073), `INST_NOP` (32'h0000_0013), fetch state enum {RUN, HALT}.
- One natural sub-module: `if_id_reg` (valid/ready register holding inst, pc, pc4; load, hold, flush controls). PC logic and FSM stay in `fetch_stage`.

## Test plan
- Reset then free-run, `id_ready`=1, memory {0:000100b7, 1:00010117, 2:008000ef}: `id_pc` 0,4,8 on consecutive cycles, `id_inst` matches, `id_pc4` 4,8,12.
- Hold `id_ready`=0 for 3 cycles while `id_pc`=4: `id_inst`=00010117, `pc`, `imem_addr`=2 unchanged; release → next word pc=8 one cycle later.
- Redirect to 32'h0000_0010 while word at pc=8 valid: next cycle `id_valid`=0, `id_inst`=NOP_INST; following cycle `id_pc`=0x10, `id_inst`=00510193.
- ECALL at word 5 (pc 0x14): `id_inst`=00000073, `halted`=1, `pc` stays 0x14; after accept `id_valid`=0 indefinitely; redirect to 0 restarts with `halted`=0.
- Redirect_pc=32'h0000_0007: fetch from pc=4; redirect_pc=0x100: `imem_addr`=0 (wrap), `id_pc`=0x100.
- Assert `rst` low mid-stall asynchronously (between edges): outputs at reset values before next edge; `id_pc`=RESET_PC at first edge after release.
